// File: rtl/pwm_pkg.sv
// Shared types and constants for the tick-driven PWM generator and its helpers.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_edge_detect.sv
// Turns a slow divider output into a single-cycle tick enable on its rising edge.
module tick_edge_detect (
    input  logic in_clk,
    input  logic reset,
    input  logic tick_in,
    output logic tick
);

    logic tick_q;

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
        end
    end

    // A held-high input produces exactly one tick
    assign tick = tick_in & ~tick_q;

endmodule

// File: rtl/tick_pwm_generator.sv
// Programmable PWM advancing one step per divider tick, with period/duty
// double-buffered so updates only land on a period boundary.
module tick_pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    input  logic             load,
    output logic             pwm_out,
    output logic             period_done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_period_q, active_period_d;
    logic [WIDTH-1:0] active_duty_q, active_duty_d;
    logic [WIDTH-1:0] pend_period_q, pend_period_d;
    logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;
    logic             apply_c;
    logic             tick;

    tick_edge_detect u_tick_edge_detect (
        .in_clk  (in_clk),
        .reset   (reset),
        .tick_in (tick_in),
        .tick    (tick)
    );

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            active_period_q <= '0;
            active_duty_q   <= '0;
            pend_period_q   <= '0;
            pend_duty_q     <= '0;
            pend_valid_q    <= 1'b0;
            pwm_q           <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            active_period_q <= active_period_d;
            active_duty_q   <= active_duty_d;
            pend_period_q   <= pend_period_d;
            pend_duty_q     <= pend_duty_d;
            pend_valid_q    <= pend_valid_d;
            pwm_q           <= pwm_d;
            done_q          <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        active_period_d = active_period_q;
        active_duty_d   = active_duty_q;
        pend_period_d   = pend_period_q;
        pend_duty_d     = pend_duty_q;
        pend_valid_d    = pend_valid_q;
        pwm_d           = pwm_q;
        done_d          = 1'b0;
        apply_c         = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pwm_d = 1'b0;
                if (enable) begin
                    state_d = RUN;
                    apply_c = pend_valid_q;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pwm_d   = 1'b0;
                end else begin
                    // Compare uses the pre-edge count, so the output lags cnt by a cycle
                    pwm_d = (cnt_q < active_duty_q);
                    if (tick) begin
                        if (cnt_q == active_period_q) begin
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            apply_c = pend_valid_q;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pwm_d   = 1'b0;
            end
        endcase

        if (apply_c) begin
            active_period_d = pend_period_q;
            active_duty_d   = pend_duty_q;
            pend_valid_d    = 1'b0;
        end

        // A load on a wrap edge lands after the swap, so it waits for the next wrap
        if (load) begin
            pend_period_d = period;
            pend_duty_d   = duty;
            pend_valid_d  = 1'b1;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_done = done_q;

endmodule
